// File: rtl/mantissa_normalize.sv
// mantissa_normalize: turns one beat of signed fixed-point accumulator lanes
// back into packed {sign, exp, mant} floating-point words using the shared
// block exponent of the beat. Two register stages, joined valid/ready input
// handshake, whole-pipe freeze on output backpressure.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   acc/_vld/_rdy     MACRO_DATA_WIDTH signed lanes, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   blk_exp/_vld/_rdy shared block exponent E of the beat
//   fp_out/_vld/_rdy  packed lanes {sign, exp, mant}, LSB = mant
//   fp_out_sat        at least one lane of the output beat saturated
module mantissa_normalize #(
   parameter int unsigned MACRO_DATA_WIDTH = 128,
   parameter int unsigned SIGN_WIDTH       = 1,
   parameter int unsigned MANTISSA_WIDTH   = 3,
   parameter int unsigned EXP_WIDTH        = 4,
   parameter int unsigned ACC_WIDTH        = 12
) (
   input  logic                                                         clk,
   input  logic                                                         rst_n,
   input  logic [MACRO_DATA_WIDTH*ACC_WIDTH-1:0]                        acc,
   input  logic                                                         acc_vld,
   output logic                                                         acc_rdy,
   input  logic [EXP_WIDTH-1:0]                                         blk_exp,
   input  logic                                                         blk_exp_vld,
   output logic                                                         blk_exp_rdy,
   output logic [MACRO_DATA_WIDTH*(SIGN_WIDTH+EXP_WIDTH+MANTISSA_WIDTH)-1:0] fp_out,
   output logic                                                         fp_out_vld,
   input  logic                                                         fp_out_rdy,
   output logic                                                         fp_out_sat
);

   localparam int unsigned LANE_W   = SIGN_WIDTH + EXP_WIDTH + MANTISSA_WIDTH;
   localparam int unsigned P_W      = $clog2(ACC_WIDTH);
   // Wide enough that E + p - MANTISSA_WIDTH never wraps; MSB is the sign.
   localparam int unsigned E_CALC_W = EXP_WIDTH + P_W + 2;
   localparam int unsigned SH_DOWN  = ACC_WIDTH - 1 - MANTISSA_WIDTH;
   localparam int unsigned OUT_W    = MACRO_DATA_WIDTH * LANE_W;

   // Index of the most significant set bit (0 when mag is zero).
   function automatic logic [P_W-1:0] lead_one(input logic [ACC_WIDTH-1:0] mag);
      logic [P_W-1:0] p;
      p = '0;
      for (int b = 0; b < int'(ACC_WIDTH); b++) begin
         if (mag[b]) p = P_W'(b);
      end
      return p;
   endfunction

   // Returns {sat, lane}: zero/underflow flush, overflow saturate, else normal.
   function automatic logic [LANE_W:0] pack_lane(input logic                 sign,
                                                 input logic [ACC_WIDTH-1:0] mag,
                                                 input logic [P_W-1:0]       p,
                                                 input logic [EXP_WIDTH-1:0] e_blk);
      logic [E_CALC_W-1:0]       e_s;
      logic [P_W-1:0]            sh;
      logic [MANTISSA_WIDTH-1:0] mant;
      logic [LANE_W:0]           r;
      e_s = E_CALC_W'(e_blk) + E_CALC_W'(p) - E_CALC_W'(MANTISSA_WIDTH);
      // Move the leading one to the MSB; the mantissa is the bits just below it.
      sh   = P_W'(ACC_WIDTH - 1) - p;
      mant = MANTISSA_WIDTH'((mag << sh) >> SH_DOWN);
      if (mag == '0 || e_s[E_CALC_W-1]) begin
         r = '0;
      end else if (e_s[E_CALC_W-2:EXP_WIDTH] != '0) begin
         r = {1'b1, {SIGN_WIDTH{sign}}, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b1}}};
      end else begin
         r = {1'b0, {SIGN_WIDTH{sign}}, e_s[EXP_WIDTH-1:0], mant};
      end
      return r;
   endfunction

   logic stall_c;
   logic xfer_c;

   logic                 sign_d [MACRO_DATA_WIDTH];
   logic [ACC_WIDTH-1:0] mag_d  [MACRO_DATA_WIDTH];
   logic [P_W-1:0]       p_d    [MACRO_DATA_WIDTH];
   logic                 sign_q [MACRO_DATA_WIDTH];
   logic [ACC_WIDTH-1:0] mag_q  [MACRO_DATA_WIDTH];
   logic [P_W-1:0]       p_q    [MACRO_DATA_WIDTH];
   logic [EXP_WIDTH-1:0] s1_exp_q;
   logic                 s1_vld_d, s1_vld_q;

   logic [LANE_W:0]      lane_res [MACRO_DATA_WIDTH];
   logic [OUT_W-1:0]     fp_out_d, fp_out_q;
   logic                 fp_out_sat_d, fp_out_sat_q;
   logic                 fp_out_vld_d, fp_out_vld_q;

   // Join handshake: both inputs are consumed together or not at all.
   assign stall_c     = fp_out_vld_q & ~fp_out_rdy;
   assign acc_rdy     = ~stall_c & blk_exp_vld;
   assign blk_exp_rdy = ~stall_c & acc_vld;
   assign xfer_c      = acc_vld & blk_exp_vld & ~stall_c;

   // Stage 1 input: sign, magnitude and leading-one position per lane.
   always_comb begin
      for (int i = 0; i < int'(MACRO_DATA_WIDTH); i++) begin
         sign_d[i] = acc[i*ACC_WIDTH + ACC_WIDTH - 1];
         // Unsigned magnitude keeps the most negative value exact.
         mag_d[i]  = sign_d[i] ? -acc[i*ACC_WIDTH +: ACC_WIDTH] : acc[i*ACC_WIDTH +: ACC_WIDTH];
         p_d[i]    = lead_one(mag_d[i]);
      end
      s1_vld_d = stall_c ? s1_vld_q : xfer_c;
   end

   // Stage 1 registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(MACRO_DATA_WIDTH); i++) begin
            sign_q[i] <= 1'b0;
            mag_q[i]  <= '0;
            p_q[i]    <= '0;
         end
         s1_exp_q <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= s1_vld_d;
         if (xfer_c) begin
            for (int i = 0; i < int'(MACRO_DATA_WIDTH); i++) begin
               sign_q[i] <= sign_d[i];
               mag_q[i]  <= mag_d[i];
               p_q[i]    <= p_d[i];
            end
            s1_exp_q <= blk_exp;
         end
      end
   end

   // Stage 2 input: normalise every lane and OR the saturation flags.
   always_comb begin
      lane_res     = '{default: '0};
      fp_out_d     = '0;
      fp_out_sat_d = 1'b0;
      for (int i = 0; i < int'(MACRO_DATA_WIDTH); i++) begin
         lane_res[i] = pack_lane(sign_q[i], mag_q[i], p_q[i], s1_exp_q);
         fp_out_d[i*LANE_W +: LANE_W] = lane_res[i][LANE_W-1:0];
         fp_out_sat_d = fp_out_sat_d | lane_res[i][LANE_W];
      end
      fp_out_vld_d = stall_c ? fp_out_vld_q : s1_vld_q;
   end

   // Stage 2 (output) registers; frozen while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fp_out_q     <= '0;
         fp_out_sat_q <= 1'b0;
         fp_out_vld_q <= 1'b0;
      end else begin
         fp_out_vld_q <= fp_out_vld_d;
         if (!stall_c) begin
            fp_out_q     <= fp_out_d;
            fp_out_sat_q <= fp_out_sat_d;
         end
      end
   end

   assign fp_out     = fp_out_q;
   assign fp_out_sat = fp_out_sat_q;
   assign fp_out_vld = fp_out_vld_q;

endmodule

// File: doc/mantissa_normalize.md
# mantissa_normalize

Converts one beat of MACRO_DATA_WIDTH signed fixed-point accumulator lanes back into packed sign/exponent/mantissa floating-point words, using the shared block exponent that was used for alignment on the input side. It sits at the output of the macro datapath, after accumulation. Each lane is normalised independently: leading-one detection, left/right shift, truncation, and exponent rebias. A 2-stage pipeline carries a valid/ready handshake and a global stall.

## Interface
- MACRO_DATA_WIDTH, 128, lanes per beat
- SIGN_WIDTH, 1, sign field bits per output lane
- MANTISSA_WIDTH, 3, stored mantissa bits (hidden 1 not stored)
- EXP_WIDTH, 4, exponent field bits (unsigned code, no denormals)
- ACC_WIDTH, 12, signed two's-complement accumulator bits per lane
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- acc  in  MACRO_DATA_WIDTH*ACC_WIDTH  lane i at [i*ACC_WIDTH +: ACC_WIDTH]
- acc_vld  in  1  acc valid
- acc_rdy  out  1  acc accepted
- blk_exp  in  EXP_WIDTH  shared block exponent E for the beat
- blk_exp_vld  in  1  blk_exp valid
- blk_exp_rdy  out  1  blk_exp accepted
- fp_out  out  MACRO_DATA_WIDTH*(SIGN_WIDTH+EXP_WIDTH+MANTISSA_WIDTH)  lane i packed as {sign, exp, mant}, LSB = mant
- fp_out_vld  out  1  output valid
- fp_out_rdy  in  1  downstream ready
- fp_out_sat  out  1  at least one lane in this beat saturated; aligned with fp_out

## Operation
- Lane value = A × 2^(E − MANTISSA_WIDTH), with A the signed lane.
- sign = A[ACC_WIDTH-1]. |A| is held as ACC_WIDTH-bit unsigned, so −2^(ACC_WIDTH−1) is exact.
- p = index of the leading one of |A|, range 0..ACC_WIDTH−1.
- Output exponent e = E + p − MANTISSA_WIDTH, computed signed with ≥ EXP_WIDTH+2 bits.
- Mantissa = the MANTISSA_WIDTH bits directly below the leading one.
  - If p < MANTISSA_WIDTH, the missing low bits are zero-filled (left shift).
  - If p > MANTISSA_WIDTH, the bits below the mantissa window are discarded (truncate magnitude, round toward zero).
- A = 0: lane output is all zeros (sign 0, exp 0, mant 0).
- e < 0 (underflow): lane output flushes to all zeros, sign also 0.
- e > 2^EXP_WIDTH − 1 (overflow): exp = all ones, mant = all ones, sign kept; the lane contributes to fp_out_sat.
- Otherwise exp = e[EXP_WIDTH−1:0]. Exp code 0 is a normal value.
- Stage 1 registers per lane: sign, |A|, p, E, plus stage valid.
- Stage 2 (output register) holds the shifted mantissa, the final exponent, the zero/flush/saturate muxing, and fp_out_sat (OR over lanes).

## Timing
- Reset: fp_out = 0, fp_out_vld = 0, fp_out_sat = 0, all stage-1 registers and valid = 0.
- stall = fp_out_vld & ~fp_out_rdy. While stall is high, both stages hold every register.
- Join handshake:
  - acc_rdy = ~stall & blk_exp_vld.
  - blk_exp_rdy = ~stall & acc_vld.
  - A transfer occurs only when acc_vld & blk_exp_vld & ~stall; both inputs are consumed in the same cycle, never one alone.
- Latency: a beat accepted in cycle N appears on fp_out with fp_out_vld = 1 in cycle N+2, provided no stall occurs.
- Throughput: one beat per cycle when fp_out_rdy is held high.
- Bubbles: when not stalled, stage 1 valid loads the transfer condition each cycle and fp_out_vld loads stage-1 valid, so bubbles propagate. Bubbles are not collapsed under stall; the whole pipe freezes.
- While fp_out_vld = 1 and fp_out_rdy = 0, fp_out and fp_out_sat must stay constant.
- Output data under fp_out_vld = 0 is don't-care but must be deterministic (registered from stage 1).
- Reset asserted mid-stream drops all in-flight beats. The first beat accepted after release appears 2 cycles after acceptance.

## Test plan
- Default params, lane0 A=+8, E=5 -> lane0 = 0_0101_000. Lane1 A=−13, E=5 -> 1_0101_101. Lane2 A=3, E=6 -> 0_0100_100. fp_out_vld rises exactly 2 cycles after the transfer.
- Truncation: A=31, E=3 -> 0_0100_111. Extreme negative: A=−2048, E=0 -> 1_1000_000.
- Boundaries:
  - A=+1, E=2 -> 0x00 (underflow flush).
  - A=0, any E -> 0x00.
  - A=+2047, E=10 -> 0_1111_111 with fp_out_sat=1.
  - A beat with no saturating lane -> fp_out_sat=0.
- Backpressure: stream 10 beats with random values and fp_out_rdy toggling randomly. Required: no loss, no duplication, and order preserved against a scoreboard; fp_out held stable while stalled; acc_rdy=0 whenever stall=1.
- Join: drive acc_vld=1 with blk_exp_vld=0 for 3 cycles -> acc_rdy=0 and nothing enters the pipe. Then raise blk_exp_vld -> exactly one beat is accepted.
- Reset mid-operation: assert rst_n low with 2 beats in flight -> all outputs read 0 immediately (asynchronous). After release, a new beat appears 2 cycles after its acceptance and no stale beat is ever emitted.
